// File: rtl/spi_rx_loader.sv
// spi_rx_loader: SPI (mode 0, MSB first) to memory word-write bridge used for program preload.
// Optional macro SPI_RX_BURST_EN: consecutive data words in one frame write to incrementing addresses.
module spi_rx_loader #(
    parameter logic [7:0]  WRITE_CMD = 8'h02,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_sdi0,
    output logic              spi_sdo0,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned SYNC_W = 3;

    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DROP
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [SYNC_W-1:0] sclk_sync_q;
    logic [SYNC_W-1:0] sdi_sync_q;
    logic [1:0]        cs_sync_q;

    logic              sclk_rise;
    logic              sdi_bit;
    logic              cs_high;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [ADDR_W-1:0] addr_q;

    logic              cnt_clr;
    logic              addr_load;
    logic              word_done;

    wr_req_t           buf_q;
    logic              buf_valid_q;
    logic              buf_valid_d;
    logic              grant;
    logic              accept;
    logic              overflow;
    logic              err_q;
    logic              busy_q;

    // Pin synchronizers; sclk and sdi carry a third stage for edge detect and aligned sampling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            cs_sync_q   <= '1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_W-2:0], spi_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_W-2:0], spi_sdi0};
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sdi_bit   = sdi_sync_q[2];
    assign cs_high   = cs_sync_q[1];
    assign shift_d   = {shift_q[DATA_W-2:0], sdi_bit};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame decode: counter reloads on each state entry, cs high aborts from any state.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        addr_load = 1'b0;
        word_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cs_high) begin
                    state_d = CMD;
                    cnt_clr = 1'b1;
                end
            end
            CMD: begin
                if (sclk_rise && (cnt_q == CMD_LAST)) begin
                    cnt_clr = 1'b1;
                    state_d = (shift_d[7:0] == WRITE_CMD) ? ADDR : DROP;
                end
            end
            ADDR: begin
                if (sclk_rise && (cnt_q == WORD_LAST)) begin
                    cnt_clr   = 1'b1;
                    addr_load = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (sclk_rise && (cnt_q == WORD_LAST)) begin
                    cnt_clr   = 1'b1;
                    word_done = 1'b1;
`ifdef SPI_RX_BURST_EN
                    state_d   = DATA;
`else
                    state_d   = DROP;
`endif
                end
            end
            DROP: begin
                state_d = DROP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_high) begin
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            addr_load = 1'b0;
            word_done = 1'b0;
        end
    end

    // Bit counter and shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (sclk_rise) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (sclk_rise) begin
                shift_q <= shift_d;
            end
        end
    end

    // Target address; in burst mode it advances per completed word, overflowed or not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else if (addr_load) begin
            addr_q <= ADDR_W'(shift_d);
`ifdef SPI_RX_BURST_EN
        end else if (word_done) begin
            addr_q <= addr_q + WORD_STEP;
`endif
        end
    end

    assign grant       = buf_valid_q & mem_gnt_i;
    assign accept      = word_done & (~buf_valid_q | mem_gnt_i);
    assign overflow    = word_done & buf_valid_q & ~mem_gnt_i;
    assign buf_valid_d = accept | (buf_valid_q & ~grant);

    // One-entry request buffer plus sticky overflow and busy status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            if (accept) begin
                buf_q.addr <= {addr_q[ADDR_W-1:2], 2'b00};
                buf_q.data <= shift_d;
            end
            if (overflow) begin
                err_q <= 1'b1;
            end
            busy_q <= ~cs_high | buf_valid_d;
        end
    end

    assign mem_req_o   = buf_valid_q;
    assign mem_we_o    = buf_valid_q;
    assign mem_addr_o  = buf_q.addr;
    assign mem_wdata_o = buf_q.data;
    assign mem_be_o    = 4'hF;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign spi_sdo0    = 1'b0;

endmodule

// File: tb/tb_spi_rx_loader.sv
// Scoreboard bench for spi_rx_loader: drives SPI frames, models expected writes, checks the memory port.
module tb_spi_rx_loader;

    localparam int unsigned HALF_NS = 30;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_sdi0;
    logic        spi_sdo0;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        busy_o;
    logic        err_o;

    int checks     = 0;
    int errors     = 0;
    int writes     = 0;
    int req_cycles = 0;
    int gnt_mode   = 2;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        prev_req;
    logic        prev_gnt;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    spi_rx_loader dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .spi_sclk    (spi_sclk),
        .spi_cs      (spi_cs),
        .spi_sdi0    (spi_sdi0),
        .spi_sdo0    (spi_sdo0),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Grant pattern: 0 tied high, 1 random, 2 held low; changes just after each edge.
    always @(posedge clk_i) begin
        #1;
        case (gnt_mode)
            0:       mem_gnt_i = 1'b1;
            1:       mem_gnt_i = 1'($urandom_range(0, 1));
            default: mem_gnt_i = 1'b0;
        endcase
    end

    // Memory-port monitor: handshake stability and scoreboard compare on each accepted transfer.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_req = 1'b0;
            prev_gnt = 1'b0;
        end else begin
            if (prev_req && !prev_gnt) begin
                check("hold_req", 32'(mem_req_o), 32'd1);
                check("hold_addr", mem_addr_o, prev_addr);
                check("hold_data", mem_wdata_o, prev_data);
            end
`ifndef SPI_RX_BURST_EN
            if (prev_req && prev_gnt) begin
                check("req_clr", 32'(mem_req_o), 32'd0);
            end
`endif
            if (mem_req_o) begin
                req_cycles++;
            end
            if (mem_req_o && mem_gnt_i) begin
                writes++;
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("wr_addr", mem_addr_o, mon_e.addr);
                    check("wr_data", mem_wdata_o, mon_e.data);
                    check("wr_be", 32'(mem_be_o), 32'hF);
                    check("wr_we", 32'(mem_we_o), 32'd1);
                end
            end
            prev_req  = mem_req_o;
            prev_gnt  = mem_gnt_i;
            prev_addr = mem_addr_o;
            prev_data = mem_wdata_o;
        end
    end

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_sdi0 = v[i];
            #(HALF_NS) spi_sclk = 1'b1;
            #(HALF_NS) spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge clk_i);
        #3 spi_cs = 1'b0;
        #40;
    endtask

    task automatic cs_high();
        #(HALF_NS) spi_cs = 1'b1;
        #60;
    endtask

    task automatic write_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        cs_low();
        send_bits(32'(cmd), 8);
        send_bits(addr, 32);
        send_bits(data, 32);
        cs_high();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!mem_req_o && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        #3;
        check("req_rise", 32'(mem_req_o), 32'd1);
    endtask

    initial begin
        int w0;
        int rc0;

        rst_ni   = 1'b0;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_sdi0 = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_be", 32'(mem_be_o), 32'hF);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_sdo", 32'(spi_sdo0), 32'd0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        gnt_mode = 0;
        repeat (5) @(posedge clk_i);

        // Single write with grant tied high: exactly one request cycle.
        w0  = writes;
        rc0 = req_cycles;
        push_exp(32'h80, 32'hDEADBEEF);
        write_frame(8'h02, 32'h80, 32'hDEADBEEF);
        drain(200);
        repeat (5) @(posedge clk_i);
        check("single_writes", 32'(writes - w0), 32'd1);
        check("single_req_cycles", 32'(req_cycles - rc0), 32'd1);
        check("single_err", 32'(err_o), 32'd0);

        // Stalled grant.
        gnt_mode = 2;
        push_exp(32'h200, 32'h12345678);
        write_frame(8'h02, 32'h200, 32'h12345678);
        wait_req(100);
        repeat (20) @(posedge clk_i);
        #3 check("stall_held", 32'(mem_req_o), 32'd1);
        gnt_mode = 0;
        drain(50);

        // Ignored command.
        w0  = writes;
        rc0 = req_cycles;
        cs_low();
        send_bits(32'h03, 8);
        send_bits(32'h100, 32);
        send_bits(32'h0, 16);
        check("ign_busy_mid", 32'(busy_o), 32'd1);
        send_bits(32'h1, 16);
        cs_high();
        repeat (10) @(posedge clk_i);
        #3 check("ign_busy_after", 32'(busy_o), 32'd0);
        check("ign_req_cycles", 32'(req_cycles - rc0), 32'd0);

        // Abort after 20 address bits, then a full write.
        w0 = writes;
        cs_low();
        send_bits(32'h02, 8);
        send_bits(32'h12345, 20);
        cs_high();
        push_exp(32'h84, 32'h00000FFF);
        write_frame(8'h02, 32'h84, 32'h00000FFF);
        drain(200);
        repeat (5) @(posedge clk_i);
        check("abort_writes", 32'(writes - w0), 32'd1);

`ifndef SPI_RX_BURST_EN
        // Extra bits after the data word are ignored.
        w0 = writes;
        push_exp(32'h300, 32'hA5A5A5A5);
        cs_low();
        send_bits(32'h02, 8);
        send_bits(32'h300, 32);
        send_bits(32'hA5A5A5A5, 32);
        send_bits(32'hCAFEF00D, 32);
        cs_high();
        drain(200);
        repeat (20) @(posedge clk_i);
        check("extra_writes", 32'(writes - w0), 32'd1);
`endif

        // Preload sequence with random grant; reset lands mid-frame 10.
        gnt_mode = 1;
        w0 = writes;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                cs_low();
                send_bits(32'h02, 8);
                send_bits(32'h80 + 32'(4 * i), 32);
                rst_ni = 1'b0;
                #20 rst_ni = 1'b1;
                send_bits(32'(i), 32);
                cs_high();
                repeat (10) @(posedge clk_i);
                #3 check("pre_rst_err", 32'(err_o), 32'd0);
                check("pre_rst_req", 32'(mem_req_o), 32'd0);
            end else begin
                push_exp(32'h80 + 32'(4 * i), 32'(i));
                write_frame(8'h02, 32'h80 + 32'(4 * i), 32'(i));
            end
            drain(2000);
        end
        repeat (10) @(posedge clk_i);
        check("pre_writes", 32'(writes - w0), 32'd31);
        check("pre_err", 32'(err_o), 32'd0);

`ifdef SPI_RX_BURST_EN
        // Burst across the address wrap with a long stall: second word overflows.
        gnt_mode = 2;
        push_exp(32'hFFFFFFFC, 32'h11111111);
        push_exp(32'h00000004, 32'h33333333);
        cs_low();
        send_bits(32'h02, 8);
        send_bits(32'hFFFFFFFC, 32);
        send_bits(32'h11111111, 32);
        fork
            begin
                send_bits(32'h22222222, 32);
                send_bits(32'h33333333, 32);
            end
            begin
                wait_req(100);
                repeat (200) @(posedge clk_i);
                gnt_mode = 0;
            end
        join
        cs_high();
        drain(500);
        check("burst_err", 32'(err_o), 32'd1);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
